bus_cycle_sequencer: RTL and testbench
======================================

BUS_CYCLE_SEQUENCER -- requirements
Module: bus_cycle_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: cpu_addr  input  16  CPU address bus.
REQ-004 SHALL have port: cpu_rw  input  1  CPU read/write (1 = read, 0 = write).
REQ-005 SHALL have port: cpu_sync  input  1  CPU opcode-fetch indicator.
REQ-006 SHALL have port: cpu_dout  input  8  CPU write data.
REQ-007 SHALL have port: mem_ready  input  1  external memory ready (1 = complete).
REQ-008 SHALL have port: pin_din  input  8  bidirectional-pin input path.
REQ-009 SHALL have port: pin_out  output  8  time-multiplexed address/control pins.
REQ-010 SHALL have port: pin_dout  output  8  bidirectional-pin output path.
REQ-011 SHALL have port: pin_oe  output  8  bidirectional-pin enables (1 = drive).
REQ-012 SHALL have port: phase  output  3  current state encoding, for the external demultiplexer.
REQ-013 SHALL have port: cpu_clk  output  1  registered CPU clock.
REQ-014 SHALL have port: cpu_din  output  8  latched read data to CPU.
REQ-015 SHALL have port: cycle_done  output  1  one-clk pulse per completed bus cycle.
REQ-016 SHALL have port: bus_err  output  1  sticky wait-timeout flag.

Function
REQ-017 SHALL implement a five-state FSM: S_CLK(0) -> S_ALO(1) -> S_AHI(2) -> S_CTL(3) -> S_DATA(4) -> S_CLK; phase = state code.
REQ-018 SHALL spend exactly 1 clk in each of S_CLK, S_ALO, S_AHI and S_CTL; S_DATA lasts 1 clk plus wait states (REQ-025).
REQ-019 SHALL drive cpu_clk = 1 only during S_CLK, 0 in all other states; CPU cycle = 5 clk with no waits.
REQ-020 SHALL capture cpu_addr, cpu_rw, cpu_sync and cpu_dout into a snapshot on the edge S_CLK -> S_ALO; snapshot held constant until the next such edge.
REQ-021 SHALL drive pin_out from state and snapshot only (no combinational path from cpu_* inputs): S_ALO = addr[7:0]; S_AHI = addr[15:8]; S_CTL = {6'b0, sync, rw}; S_CLK and S_DATA = 8'h00.
REQ-022 SHALL drive pin_oe = 8'hFF and pin_dout = snapshot dout during S_DATA when snapshot rw = 0; otherwise pin_oe = 8'h00, pin_dout = 8'h00.
REQ-023 SHALL latch pin_din into cpu_din on the edge leaving S_DATA when snapshot rw = 1; cpu_din holds its value on write cycles.
REQ-024 SHALL assert cycle_done for exactly the 1 clk following S_DATA exit (coincident with S_CLK).
REQ-025 With waits enabled: S_DATA exits when mem_ready = 1 at a clk edge; while mem_ready = 0 a 4-bit wait counter increments from 0.
REQ-026 SHALL force S_DATA exit when the wait counter = 15 and mem_ready is still 0, latch pin_din as for a normal read, and set bus_err = 1.
REQ-027 bus_err SHALL remain 1 until reset; the wait counter SHALL clear to 0 on every S_DATA entry.
REQ-028 mem_ready SHALL be ignored in all states other than S_DATA.

Reset
REQ-029 rst_n = 0 at a clk edge SHALL force state S_CLK, cpu_clk = 0, pin_out = 8'h00, pin_dout = 8'h00, pin_oe = 8'h00, cpu_din = 8'h00, cycle_done = 0, bus_err = 0, wait counter = 0, snapshot = 0; registered outputs take these values on that edge.
REQ-030 A reset asserted mid-cycle (any state, including mid-wait) SHALL abandon the cycle without a cycle_done pulse; pin_oe SHALL be 0 from the reset edge.
REQ-031 The first clk after reset release SHALL be S_CLK with cpu_clk = 1.

Configuration
REQ-032 Macro BUS_SEQ_WAIT_EN defined: REQ-025 to REQ-027 active.
REQ-033 Macro BUS_SEQ_WAIT_EN undefined: S_DATA lasts exactly 1 clk; mem_ready ignored; wait counter absent; bus_err tied to 0.

Verification
REQ-034 Read, cpu_addr=16'hC0DE, rw=1, sync=1, mem_ready=1 -> pin_out DE, C0, 03, 00 in S_ALO..S_DATA; pin_din=8'h5A -> cpu_din=5A; cycle_done 1 clk; period 5 clk.
REQ-035 Write, cpu_addr=16'h0200, rw=0, cpu_dout=8'hA5 -> pin_out 00, 02, 00; pin_oe=FF and pin_dout=A5 only in S_DATA.
REQ-036 (WAIT_EN) mem_ready=0 for 3 clk in S_DATA -> S_DATA lasts 4 clk, CPU cycle = 8 clk, bus_err = 0.
REQ-037 (WAIT_EN) mem_ready held 0 -> forced exit after 16 clk in S_DATA, bus_err = 1 and stays 1 through later good cycles until reset.
REQ-038 rst_n=0 during an S_DATA write -> next clk pin_oe=00, state S_CLK, no cycle_done; after release cpu_clk=1 first clk.
REQ-039 Without BUS_SEQ_WAIT_EN, mem_ready=0 constantly -> period stays 5 clk, bus_err = 0.

Source files
------------

// File: rtl/bus_cycle_sequencer_if.sv
// Bus bundle for bus_cycle_sequencer.
//   CPU side    : cpu_addr, cpu_rw, cpu_sync, cpu_dout (to sequencer), cpu_clk, cpu_din (from sequencer)
//   Memory side : mem_ready, pin_din (to sequencer), pin_out, pin_dout, pin_oe, phase (from sequencer)
//   Status      : cycle_done, bus_err (from sequencer)
// modport slave is the sequencer's view; modport master is the environment driving it.
interface bus_cycle_sequencer_if;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic        cpu_sync;
  logic [7:0]  cpu_dout;
  logic        mem_ready;
  logic [7:0]  pin_din;
  logic [7:0]  pin_out;
  logic [7:0]  pin_dout;
  logic [7:0]  pin_oe;
  logic [2:0]  phase;
  logic        cpu_clk;
  logic [7:0]  cpu_din;
  logic        cycle_done;
  logic        bus_err;

  modport slave (
    input  cpu_addr, cpu_rw, cpu_sync, cpu_dout, mem_ready, pin_din,
    output pin_out, pin_dout, pin_oe, phase, cpu_clk, cpu_din, cycle_done, bus_err
  );

  modport master (
    output cpu_addr, cpu_rw, cpu_sync, cpu_dout, mem_ready, pin_din,
    input  pin_out, pin_dout, pin_oe, phase, cpu_clk, cpu_din, cycle_done, bus_err
  );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer: turns one CPU bus cycle into a five-phase multiplexed
// external bus cycle (address low, address high, control, data) and produces
// the CPU clock.
//
// Ports:
//   clk   - system clock, all state changes on rising edge
//   rst_n - synchronous active-low reset
//   bus   - bus_cycle_sequencer_if.slave (CPU inputs, pin/memory signals,
//           cpu_clk, cpu_din, cycle_done, bus_err, phase)
//
// Build option: define BUS_SEQ_WAIT_EN to enable memory wait states with a
// 15-count timeout (sticky bus_err). Without it S_DATA is always one clk and
// bus_err reads 0.
//
// state  | meaning
// S_CLK  | cpu_clk high; CPU inputs captured on exit
// S_ALO  | address low byte on pin_out
// S_AHI  | address high byte on pin_out
// S_CTL  | {sync, rw} on pin_out
// S_DATA | data transfer; write data driven, read data latched on exit
module bus_cycle_sequencer (
  input  logic                  clk,
  input  logic                  rst_n,
  bus_cycle_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_CLK  = 3'd0,
    S_ALO  = 3'd1,
    S_AHI  = 3'd2,
    S_CTL  = 3'd3,
    S_DATA = 3'd4
  } state_t;

  state_t      state_q, state_d;
  // Low for the first clk after reset so that clk shows S_CLK with cpu_clk high.
  logic        run_q, run_d;

  logic [15:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic        sync_q, sync_d;
  logic [7:0]  dout_q, dout_d;

  logic        cpu_clk_q, cpu_clk_d;
  logic [7:0]  pin_out_q, pin_out_d;
  logic [7:0]  pin_dout_q, pin_dout_d;
  logic [7:0]  pin_oe_q, pin_oe_d;
  logic [7:0]  cpu_din_q, cpu_din_d;
  logic        cycle_done_q, cycle_done_d;
  logic        data_exit;

`ifdef BUS_SEQ_WAIT_EN
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        bus_err_q, bus_err_d;
`endif

  always_comb begin
    state_d   = state_q;
    run_d     = 1'b1;
    addr_d    = addr_q;
    rw_d      = rw_q;
    sync_d    = sync_q;
    dout_d    = dout_q;
    cpu_din_d = cpu_din_q;
    data_exit = 1'b0;
`ifdef BUS_SEQ_WAIT_EN
    wait_cnt_d = 4'd0;
    bus_err_d  = bus_err_q;
`endif

    case (state_q)
      S_CLK: begin
        if (run_q) begin
          state_d = S_ALO;
          addr_d  = bus.cpu_addr;
          rw_d    = bus.cpu_rw;
          sync_d  = bus.cpu_sync;
          dout_d  = bus.cpu_dout;
        end
      end
      S_ALO:  state_d = S_AHI;
      S_AHI:  state_d = S_CTL;
      S_CTL:  state_d = S_DATA;
      S_DATA: begin
`ifdef BUS_SEQ_WAIT_EN
        // Counter is zero on entry because it clears whenever not counting.
        if (bus.mem_ready) begin
          data_exit = 1'b1;
        end else if (wait_cnt_q == 4'd15) begin
          data_exit = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
`else
        data_exit = 1'b1;
`endif
      end
      default: state_d = S_CLK;
    endcase

    if (data_exit) begin
      state_d = S_CLK;
      if (rw_q) begin
        cpu_din_d = bus.pin_din;
      end
    end

    // Outputs are registered from the next state and next snapshot, so the
    // pins never see a combinational path from the cpu_* inputs.
    cycle_done_d = data_exit;
    cpu_clk_d    = (state_d == S_CLK);
    case (state_d)
      S_ALO:   pin_out_d = addr_d[7:0];
      S_AHI:   pin_out_d = addr_d[15:8];
      S_CTL:   pin_out_d = {6'b0, sync_d, rw_d};
      default: pin_out_d = 8'h00;
    endcase
    if ((state_d == S_DATA) && !rw_d) begin
      pin_oe_d   = 8'hFF;
      pin_dout_d = dout_d;
    end else begin
      pin_oe_d   = 8'h00;
      pin_dout_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_CLK;
      run_q        <= 1'b0;
      addr_q       <= 16'h0000;
      rw_q         <= 1'b0;
      sync_q       <= 1'b0;
      dout_q       <= 8'h00;
      cpu_clk_q    <= 1'b0;
      pin_out_q    <= 8'h00;
      pin_dout_q   <= 8'h00;
      pin_oe_q     <= 8'h00;
      cpu_din_q    <= 8'h00;
      cycle_done_q <= 1'b0;
`ifdef BUS_SEQ_WAIT_EN
      wait_cnt_q   <= 4'd0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      sync_q       <= sync_d;
      dout_q       <= dout_d;
      cpu_clk_q    <= cpu_clk_d;
      pin_out_q    <= pin_out_d;
      pin_dout_q   <= pin_dout_d;
      pin_oe_q     <= pin_oe_d;
      cpu_din_q    <= cpu_din_d;
      cycle_done_q <= cycle_done_d;
`ifdef BUS_SEQ_WAIT_EN
      wait_cnt_q   <= wait_cnt_d;
      bus_err_q    <= bus_err_d;
`endif
    end
  end

  assign bus.phase      = state_q;
  assign bus.cpu_clk    = cpu_clk_q;
  assign bus.pin_out    = pin_out_q;
  assign bus.pin_dout   = pin_dout_q;
  assign bus.pin_oe     = pin_oe_q;
  assign bus.cpu_din    = cpu_din_q;
  assign bus.cycle_done = cycle_done_q;
`ifdef BUS_SEQ_WAIT_EN
  assign bus.bus_err    = bus_err_q;
`else
  assign bus.bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Self-checking bench for bus_cycle_sequencer: a table of directed bus
// cycles, hand-written reset/sticky-error sequences, then random cycles
// checked against a transaction-level expectation model.
module tb_bus_cycle_sequencer;

`ifdef BUS_SEQ_WAIT_EN
  localparam bit WAIT_ON = 1'b1;
`else
  localparam bit WAIT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_cycle_sequencer_if bif ();

  bus_cycle_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model state carried between transactions.
  logic [7:0] model_din = 8'h00;
  logic       model_err = 1'b0;

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic        sync;
    logic [7:0]  dout;
    logic [7:0]  din;
    int          nw;
    logic [7:0]  e_lo;
    logic [7:0]  e_hi;
    logic [7:0]  e_ctl;
    int          e_len;
    logic [7:0]  e_din;
    logic        e_err;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one bus cycle starting from S_CLK. nw = number of clks mem_ready is
  // held low in the data phase.
  task automatic do_cycle(input logic [15:0] a, input logic rw, input logic sy,
                          input logic [7:0] dq, input logic [7:0] di, input int nw,
                          input logic [7:0] e_lo, input logic [7:0] e_hi,
                          input logic [7:0] e_ctl, input int e_len,
                          input logic [7:0] e_din, input logic e_err);
    int len;
    int k;
    chk("start_phase", bif.phase, 0);
    bif.cpu_addr  = a;
    bif.cpu_rw    = rw;
    bif.cpu_sync  = sy;
    bif.cpu_dout  = dq;
    bif.mem_ready = 1'($urandom_range(0, 1));
    bif.pin_din   = 8'($urandom);
    tick(); len = 1;
    // Scramble CPU inputs: the cycle must run from the captured snapshot.
    bif.cpu_addr  = 16'($urandom);
    bif.cpu_rw    = 1'($urandom_range(0, 1));
    bif.cpu_sync  = 1'($urandom_range(0, 1));
    bif.cpu_dout  = 8'($urandom);
    chk("alo_phase", bif.phase, 1);
    chk("alo_pin_out", bif.pin_out, e_lo);
    chk("alo_cpu_clk", bif.cpu_clk, 0);
    chk("alo_cycle_done", bif.cycle_done, 0);
    chk("alo_pin_oe", bif.pin_oe, 0);
    tick(); len++;
    chk("ahi_phase", bif.phase, 2);
    chk("ahi_pin_out", bif.pin_out, e_hi);
    tick(); len++;
    chk("ctl_phase", bif.phase, 3);
    chk("ctl_pin_out", bif.pin_out, e_ctl);
    chk("ctl_pin_oe", bif.pin_oe, 0);
    tick(); len++;
    chk("data_phase", bif.phase, 4);
    chk("data_pin_out", bif.pin_out, 0);
    chk("data_pin_oe", bif.pin_oe, rw ? 8'h00 : 8'hFF);
    chk("data_pin_dout", bif.pin_dout, rw ? 8'h00 : dq);
    k = 0;
    while (bif.phase == 3'd4 && len < 40) begin
      bif.mem_ready = (k >= nw);
      bif.pin_din   = di;
      tick(); len++; k++;
    end
    bif.mem_ready = 1'($urandom_range(0, 1));
    bif.pin_din   = 8'($urandom);
    chk("cycle_len", len, e_len);
    chk("end_phase", bif.phase, 0);
    chk("end_cpu_clk", bif.cpu_clk, 1);
    chk("end_cycle_done", bif.cycle_done, 1);
    chk("end_cpu_din", bif.cpu_din, e_din);
    chk("end_bus_err", bif.bus_err, e_err);
    chk("end_pin_oe", bif.pin_oe, 0);
  endtask

  initial begin
    vecs[0] = '{16'hC0DE, 1'b1, 1'b1, 8'h00, 8'h5A, 0,   8'hDE, 8'hC0, 8'h03, 5,                 8'h5A, 1'b0};
    vecs[1] = '{16'h0200, 1'b0, 1'b0, 8'hA5, 8'h33, 0,   8'h00, 8'h02, 8'h00, 5,                 8'h5A, 1'b0};
    vecs[2] = '{16'h1234, 1'b1, 1'b0, 8'h00, 8'h77, 3,   8'h34, 8'h12, 8'h01, WAIT_ON ? 8 : 5,   8'h77, 1'b0};
    vecs[3] = '{16'hFFFF, 1'b0, 1'b1, 8'h3C, 8'h11, 2,   8'hFF, 8'hFF, 8'h02, WAIT_ON ? 7 : 5,   8'h77, 1'b0};
    vecs[4] = '{16'hABCD, 1'b1, 1'b1, 8'h00, 8'hC3, 100, 8'hCD, 8'hAB, 8'h03, WAIT_ON ? 20 : 5,  8'hC3, WAIT_ON};
    vecs[5] = '{16'h5555, 1'b0, 1'b0, 8'h96, 8'h00, 0,   8'h55, 8'h55, 8'h00, 5,                 8'hC3, WAIT_ON};
    vecs[6] = '{16'h8001, 1'b1, 1'b1, 8'h00, 8'hE7, 1,   8'h01, 8'h80, 8'h03, WAIT_ON ? 6 : 5,   8'hE7, WAIT_ON};

    bif.cpu_addr  = 16'h0000;
    bif.cpu_rw    = 1'b0;
    bif.cpu_sync  = 1'b0;
    bif.cpu_dout  = 8'h00;
    bif.mem_ready = 1'b0;
    bif.pin_din   = 8'h00;

    // Reset state.
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_phase", bif.phase, 0);
    chk("rst_cpu_clk", bif.cpu_clk, 0);
    chk("rst_pin_out", bif.pin_out, 0);
    chk("rst_pin_oe", bif.pin_oe, 0);
    chk("rst_pin_dout", bif.pin_dout, 0);
    chk("rst_cpu_din", bif.cpu_din, 0);
    chk("rst_cycle_done", bif.cycle_done, 0);
    chk("rst_bus_err", bif.bus_err, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_phase", bif.phase, 0);
    chk("rel_cpu_clk", bif.cpu_clk, 1);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      do_cycle(vecs[i].addr, vecs[i].rw, vecs[i].sync, vecs[i].dout, vecs[i].din, vecs[i].nw,
               vecs[i].e_lo, vecs[i].e_hi, vecs[i].e_ctl, vecs[i].e_len, vecs[i].e_din, vecs[i].e_err);
    end

    // Reset in the data phase of a write (mid-wait when waits are enabled).
    bif.cpu_addr = 16'h4321;
    bif.cpu_rw   = 1'b0;
    bif.cpu_dout = 8'h6B;
    tick(); tick(); tick(); tick();
    chk("mid_data_phase", bif.phase, 4);
    chk("mid_data_oe", bif.pin_oe, 8'hFF);
    bif.mem_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_phase", bif.phase, 0);
    chk("mid_rst_oe", bif.pin_oe, 0);
    chk("mid_rst_cycle_done", bif.cycle_done, 0);
    chk("mid_rst_cpu_clk", bif.cpu_clk, 0);
    chk("mid_rst_bus_err", bif.bus_err, 0);
    chk("mid_rst_cpu_din", bif.cpu_din, 0);
    rst_n = 1'b1;
    tick();
    chk("mid_rel_cpu_clk", bif.cpu_clk, 1);
    chk("mid_rel_cycle_done", bif.cycle_done, 0);
    model_din = 8'h00;
    model_err = 1'b0;

    // Random cycles against the transaction model.
    for (int t = 0; t < 30; t++) begin
      logic [15:0] a;
      logic        rw, sy;
      logic [7:0]  dq, di;
      int          nw, waits;
      a  = 16'($urandom);
      rw = 1'($urandom_range(0, 1));
      sy = 1'($urandom_range(0, 1));
      dq = 8'($urandom);
      di = 8'($urandom);
      nw = ($urandom_range(0, 7) == 0) ? 16 + int'($urandom_range(0, 4)) : int'($urandom_range(0, 4));
      waits = WAIT_ON ? ((nw > 15) ? 15 : nw) : 0;
      if (rw) model_din = di;
      if (WAIT_ON && nw > 15) model_err = 1'b1;
      do_cycle(a, rw, sy, dq, di, nw, a[7:0], a[15:8], {6'b0, sy, rw},
               5 + waits, model_din, model_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
